// File: rtl/branch_mod.sv
// RV32I branch-condition evaluator with a one-cycle registered taken flag.
// Optional macro BRANCH_ILLEGAL_FLAG_EN adds a registered illegal-funct3 output.
module branch_mod #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Branch,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
`ifdef BRANCH_ILLEGAL_FLAG_EN
   output logic            illegal,
`endif
   output logic            result,
   output logic            result_valid
);

   localparam logic [2:0] F3Beq  = 3'b000;
   localparam logic [2:0] F3Bne  = 3'b001;
   localparam logic [2:0] F3Blt  = 3'b100;
   localparam logic [2:0] F3Bge  = 3'b101;
   localparam logic [2:0] F3Bltu = 3'b110;
   localparam logic [2:0] F3Bgeu = 3'b111;

   logic result_q, result_d;
   logic valid_q, valid_d;
   logic eq, lt_s, lt_u;

   assign eq   = (rs1 == rs2);
   assign lt_s = ($signed(rs1) < $signed(rs2));
   assign lt_u = (rs1 < rs2);

   always_comb begin
      result_d = 1'b0;
      valid_d  = Branch;
      if (Branch) begin
         case (funct3)
            F3Beq:   result_d = eq;
            F3Bne:   result_d = ~eq;
            F3Blt:   result_d = lt_s;
            F3Bge:   result_d = ~lt_s;
            F3Bltu:  result_d = lt_u;
            F3Bgeu:  result_d = ~lt_u;
            default: result_d = 1'b0;  // reserved 010/011
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign result       = result_q;
   assign result_valid = valid_q;

`ifdef BRANCH_ILLEGAL_FLAG_EN
   logic illegal_q, illegal_d;

   assign illegal_d = Branch & (funct3[2:1] == 2'b01);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end

   assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_branch_mod.sv
// Directed-vector bench for branch_mod with hand-computed expectations.
// Build with +define+BRANCH_ILLEGAL_FLAG_EN to also check the illegal flag.
module tb_branch_mod;

   logic        clk;
   logic        rst_n;
   logic        Branch;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        result;
   logic        result_valid;
`ifdef BRANCH_ILLEGAL_FLAG_EN
   logic        illegal;
`endif

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   branch_mod #(
      .XLEN(32)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Branch       (Branch),
      .funct3       (funct3),
      .rs1          (rs1),
      .rs2          (rs2),
`ifdef BRANCH_ILLEGAL_FLAG_EN
      .illegal      (illegal),
`endif
      .result       (result),
      .result_valid (result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one vector, clock it in, then check the registered outputs 1 time unit later.
   task automatic apply(input string tag, input logic br, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic exp_res);
      Branch = br;
      funct3 = f3;
      rs1    = a;
      rs2    = b;
      @(posedge clk);
      #1;
      check_eq($sformatf("%s.result.f%0d", tag, f3), {31'd0, result}, {31'd0, exp_res});
      check_eq($sformatf("%s.valid.f%0d", tag, f3), {31'd0, result_valid}, {31'd0, br});
`ifdef BRANCH_ILLEGAL_FLAG_EN
      check_eq($sformatf("%s.illegal.f%0d", tag, f3), {31'd0, illegal},
               {31'd0, br & (f3 == 3'b010 || f3 == 3'b011)});
`endif
   endtask

   // exp[f] is the expected taken flag for funct3 = f.
   task automatic sweep(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] exp);
      for (int f = 0; f < 8; f++) begin
         apply(tag, 1'b1, 3'(f), a, b, exp[f]);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      Branch = 1'b1;
      funct3 = 3'b000;
      rs1    = 32'hA5A5_A5A5;
      rs2    = 32'hA5A5_A5A5;
      #1;

      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_eq("rst.result", {31'd0, result}, 32'd0);
         check_eq("rst.valid", {31'd0, result_valid}, 32'd0);
      end
      rst_n = 1'b1;
      apply("rst_release", 1'b1, 3'b000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);

      sweep("equal",    32'h1234_5678, 32'h1234_5678, 8'b1010_0001);
      sweep("signsplit", 32'h1234_5678, 32'h8765_4321, 8'b0110_0010);
      sweep("samesign", 32'h1234_5678, 32'h2345_6789, 8'b0101_0010);
      sweep("neg_a",    32'hF234_5678, 32'h1234_5678, 8'b1001_0010);
      sweep("neg_b",    32'h8765_4321, 32'h1234_5678, 8'b1001_0010);

      apply("min_vs_max.blt",  1'b1, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
      apply("min_vs_max.bltu", 1'b1, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
      apply("m1_vs_0.blt",     1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      apply("m1_vs_0.bgeu",    1'b1, 3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

      // Branch=0 must suppress every code, including ones that would be taken.
      apply("disable", 1'b0, 3'b000, 32'h0000_0001, 32'h0000_0001, 1'b0);
      apply("disable", 1'b0, 3'b001, 32'h0000_0001, 32'h0000_0002, 1'b0);
      apply("disable", 1'b0, 3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      apply("disable", 1'b0, 3'b010, 32'h0000_0000, 32'h0000_0000, 1'b0);

      apply("reserved", 1'b1, 3'b010, 32'h0000_0000, 32'h0000_0000, 1'b0);
      apply("reserved", 1'b1, 3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

      // Reset wins over a taken branch in the same cycle.
      apply("pre_rst", 1'b1, 3'b000, 32'h0, 32'h0, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_prio.result", {31'd0, result}, 32'd0);
      check_eq("rst_prio.valid", {31'd0, result_valid}, 32'd0);
`ifdef BRANCH_ILLEGAL_FLAG_EN
      check_eq("rst_prio.illegal", {31'd0, illegal}, 32'd0);
`endif
      rst_n = 1'b1;
      apply("post_rst", 1'b1, 3'b001, 32'h0, 32'h1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
